// File: rtl/axi_mem_pkg.sv
// Shared response codes and FSM state types for the AXI4 slave memory endpoint.
package axi_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

endpackage

// File: rtl/axi_mem_slv_if.sv
// AXI4 subset (AW/W/B/AR/R, INCR, full-width beats) seen by the memory endpoint.
interface axi_mem_slv_if #(
    parameter int DATA_W           = 256,
    parameter int ADDR_W           = 32,
    parameter int MST_ID_W         = 5,
    parameter int TRANS_DATA_LEN_W = 8,
    parameter int TRANS_RESP_W     = 2
);
    logic [MST_ID_W-1:0]         s_awid_i;
    logic [ADDR_W-1:0]           s_awaddr_i;
    logic [TRANS_DATA_LEN_W-1:0] s_awlen_i;
    logic                        s_awvalid_i;
    logic                        s_awready_o;
    logic [DATA_W-1:0]           s_wdata_i;
    logic                        s_wlast_i;
    logic                        s_wvalid_i;
    logic                        s_wready_o;
    logic [MST_ID_W-1:0]         s_bid_o;
    logic [TRANS_RESP_W-1:0]     s_bresp_o;
    logic                        s_bvalid_o;
    logic                        s_bready_i;
    logic [MST_ID_W-1:0]         s_arid_i;
    logic [ADDR_W-1:0]           s_araddr_i;
    logic [TRANS_DATA_LEN_W-1:0] s_arlen_i;
    logic                        s_arvalid_i;
    logic                        s_arready_o;
    logic [MST_ID_W-1:0]         s_rid_o;
    logic [DATA_W-1:0]           s_rdata_o;
    logic [TRANS_RESP_W-1:0]     s_rresp_o;
    logic                        s_rlast_o;
    logic                        s_rvalid_o;
    logic                        s_rready_i;

    modport slave (
        input  s_awid_i, s_awaddr_i, s_awlen_i, s_awvalid_i,
        output s_awready_o,
        input  s_wdata_i, s_wlast_i, s_wvalid_i,
        output s_wready_o,
        output s_bid_o, s_bresp_o, s_bvalid_o,
        input  s_bready_i,
        input  s_arid_i, s_araddr_i, s_arlen_i, s_arvalid_i,
        output s_arready_o,
        output s_rid_o, s_rdata_o, s_rresp_o, s_rlast_o, s_rvalid_o,
        input  s_rready_i
    );

    modport master (
        output s_awid_i, s_awaddr_i, s_awlen_i, s_awvalid_i,
        input  s_awready_o,
        output s_wdata_i, s_wlast_i, s_wvalid_i,
        input  s_wready_o,
        input  s_bid_o, s_bresp_o, s_bvalid_o,
        output s_bready_i,
        output s_arid_i, s_araddr_i, s_arlen_i, s_arvalid_i,
        input  s_arready_o,
        input  s_rid_o, s_rdata_o, s_rresp_o, s_rlast_o, s_rvalid_o,
        output s_rready_i
    );

endinterface

// File: rtl/axi_mem_array.sv
// Word-wide storage: one synchronous write port, one asynchronous read port.
module axi_mem_array #(
    parameter int DATA_W    = 256,
    parameter int MEM_DEPTH = 1024
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [$clog2(MEM_DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]            wdata,
    input  logic [$clog2(MEM_DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]            rdata
);

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    // NOTE: storage is deliberately left out of reset so it maps onto RAM and
    // keeps committed data across a mid-burst reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // A read of the word being written this cycle returns the old contents.
    assign rdata = mem[raddr];

endmodule

// File: rtl/axi_mem_slv.sv
// AXI4 slave memory endpoint: independent write (AW/W/B) and read (AR/R) FSMs
// over a single word-addressed array.
module axi_mem_slv
    import axi_mem_pkg::*;
#(
    parameter int                DATA_W           = 256,
    parameter int                ADDR_W           = 32,
    parameter int                MST_ID_W         = 5,
    parameter int                TRANS_DATA_LEN_W = 8,
    parameter int                TRANS_RESP_W     = 2,
    parameter int                MEM_DEPTH        = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR        = '0
) (
    input logic          aclk,
    input logic          aresetn,
    axi_mem_slv_if.slave s
);

    localparam int OFF_W = $clog2(DATA_W / 8);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int LEN_W = TRANS_DATA_LEN_W;
    localparam int CNT_W = TRANS_DATA_LEN_W + 1;
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(MEM_DEPTH);

    // Borrow out of the base subtraction marks addresses below the window.
    logic [ADDR_W:0]   aw_diff, ar_diff;
    logic [ADDR_W-1:0] aw_idx, ar_idx;

    assign aw_diff = {1'b0, s.s_awaddr_i} - {1'b0, BASE_ADDR};
    assign ar_diff = {1'b0, s.s_araddr_i} - {1'b0, BASE_ADDR};
    assign aw_idx  = aw_diff[ADDR_W-1:0] >> OFF_W;
    assign ar_idx  = ar_diff[ADDR_W-1:0] >> OFF_W;

    // ---------------- write side ----------------
    w_state_e          w_state;
    logic              aw_rdy_q;
    logic [MST_ID_W-1:0] w_id;
    logic [ADDR_W-1:0] w_idx;
    logic [LEN_W-1:0]  w_len;
    logic [CNT_W-1:0]  w_cnt;
    logic              w_below, w_err;
    logic              aw_hs, w_hs, b_hs, w_keep, w_len_bad;

    assign aw_hs     = s.s_awvalid_i && aw_rdy_q;
    assign w_hs      = s.s_wvalid_i && (w_state == W_DATA);
    assign b_hs      = s.s_bready_i && (w_state == W_RESP);
    assign w_keep    = !w_below && (w_idx < DEPTH_A) && (w_cnt <= {1'b0, w_len});
    assign w_len_bad = s.s_wlast_i && (w_cnt != {1'b0, w_len});

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state  <= W_IDLE;
            aw_rdy_q <= 1'b0;
            w_id     <= '0;
            w_idx    <= '0;
            w_len    <= '0;
            w_cnt    <= '0;
            w_below  <= 1'b0;
            w_err    <= 1'b0;
        end else begin
            // Registered from the current state: ready appears one cycle after
            // reset release or after the previous B handshake.
            aw_rdy_q <= (w_state == W_IDLE) && !aw_hs;
            case (w_state)
                W_IDLE: if (aw_hs) begin
                    w_id    <= s.s_awid_i;
                    w_idx   <= aw_idx;
                    w_below <= aw_diff[ADDR_W];
                    w_len   <= s.s_awlen_i;
                    w_cnt   <= '0;
                    w_err   <= 1'b0;
                    w_state <= W_DATA;
                end
                W_DATA: if (w_hs) begin
                    w_idx <= w_idx + ADDR_W'(1);
                    w_cnt <= w_cnt + CNT_W'(1);
                    if (!w_keep || w_len_bad) begin
                        w_err <= 1'b1;
                    end
                    if (s.s_wlast_i) begin
                        w_state <= W_RESP;
                    end
                end
                W_RESP: if (b_hs) begin
                    w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    assign s.s_awready_o = aw_rdy_q;
    assign s.s_wready_o  = (w_state == W_DATA);
    assign s.s_bvalid_o  = (w_state == W_RESP);
    assign s.s_bid_o     = w_id;
    assign s.s_bresp_o   = ((w_state == W_RESP) && w_err) ? TRANS_RESP_W'(RESP_SLVERR)
                                                          : TRANS_RESP_W'(RESP_OKAY);

    // ---------------- read side ----------------
    r_state_e          r_state;
    logic              ar_rdy_q;
    logic [MST_ID_W-1:0] r_id;
    logic [ADDR_W-1:0] r_idx;
    logic [LEN_W-1:0]  r_len;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_below;
    logic              ar_hs, r_hs, r_valid, r_last, r_in_range;
    logic [DATA_W-1:0] mem_rdata;

    assign ar_hs      = s.s_arvalid_i && ar_rdy_q;
    assign r_valid    = (r_state == R_DATA);
    assign r_hs       = s.s_rready_i && r_valid;
    assign r_last     = (r_cnt == {1'b0, r_len});
    assign r_in_range = !r_below && (r_idx < DEPTH_A);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state  <= R_IDLE;
            ar_rdy_q <= 1'b0;
            r_id     <= '0;
            r_idx    <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_below  <= 1'b0;
        end else begin
            ar_rdy_q <= (r_state == R_IDLE) && !ar_hs;
            case (r_state)
                R_IDLE: if (ar_hs) begin
                    r_id    <= s.s_arid_i;
                    r_idx   <= ar_idx;
                    r_below <= ar_diff[ADDR_W];
                    r_len   <= s.s_arlen_i;
                    r_cnt   <= '0;
                    r_state <= R_DATA;
                end
                R_DATA: if (r_hs) begin
                    r_idx <= r_idx + ADDR_W'(1);
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_last) begin
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign s.s_arready_o = ar_rdy_q;
    assign s.s_rvalid_o  = r_valid;
    assign s.s_rid_o     = r_id;
    assign s.s_rlast_o   = r_valid && r_last;
    assign s.s_rdata_o   = (r_valid && r_in_range) ? mem_rdata : '0;
    assign s.s_rresp_o   = (r_valid && !r_in_range) ? TRANS_RESP_W'(RESP_SLVERR)
                                                    : TRANS_RESP_W'(RESP_OKAY);

    axi_mem_array #(
        .DATA_W    (DATA_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_array (
        .clk   (aclk),
        .we    (w_hs && w_keep),
        .waddr (w_idx[IDX_W-1:0]),
        .wdata (s.s_wdata_i),
        .raddr (r_idx[IDX_W-1:0]),
        .rdata (mem_rdata)
    );

endmodule

// File: doc/axi_mem_slv.md
Name: axi_mem_slv

Overview:
- AXI4 slave memory endpoint that answers the DMA's master ports.
- Its write side accepts AW/W bursts and returns B, terminating one destination channel.
- Its read side accepts AR and returns R bursts, acting as the source memory.
- Used as the system-level target for DMA destination/source channels and as the bench memory for DMA verification; INCR bursts, full-width beats only.

Parameters:
- DATA_W, 256, data bus width in bits; power of two, >= 8.
- ADDR_W, 32, byte address width.
- MST_ID_W, 5, transaction ID width.
- TRANS_DATA_LEN_W, 8, burst length field width (beats = len+1).
- TRANS_RESP_W, 2, response width.
- MEM_DEPTH, 1024, number of DATA_W-wide words.
- BASE_ADDR, 0, byte address of word 0.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- s_awid_i  in  MST_ID_W  write ID.
- s_awaddr_i  in  ADDR_W  write start byte address.
- s_awlen_i  in  TRANS_DATA_LEN_W  write beats-1.
- s_awvalid_i  in  1  AW valid.
- s_awready_o  out  1  AW ready.
- s_wdata_i  in  DATA_W  write data.
- s_wlast_i  in  1  last write beat.
- s_wvalid_i  in  1  W valid.
- s_wready_o  out  1  W ready.
- s_bid_o  out  MST_ID_W  response ID.
- s_bresp_o  out  TRANS_RESP_W  write response.
- s_bvalid_o  out  1  B valid.
- s_bready_i  in  1  B ready.
- s_arid_i  in  MST_ID_W  read ID.
- s_araddr_i  in  ADDR_W  read start byte address.
- s_arlen_i  in  TRANS_DATA_LEN_W  read beats-1.
- s_arvalid_i  in  1  AR valid.
- s_arready_o  out  1  AR ready.
- s_rid_o  out  MST_ID_W  read ID.
- s_rdata_o  out  DATA_W  read data.
- s_rresp_o  out  TRANS_RESP_W  per-beat read response.
- s_rlast_o  out  1  last read beat.
- s_rvalid_o  out  1  R valid.
- s_rready_i  in  1  R ready.

Behaviour:
- Reset: clock aclk, reset aresetn asynchronous active-low. All ready/valid/last outputs are 0 during reset; IDs, resp and data are 0. Memory contents are not reset. s_awready_o and s_arready_o rise on the first clock edge after release.
- Addressing: word index = (addr - BASE_ADDR) >> log2(DATA_W/8); low offset bits are ignored. A beat is out of range if its index >= MEM_DEPTH or addr < BASE_ADDR. The index increments by 1 per beat with no wrap; each beat is checked independently.
- Write FSM, W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready=1. On AW handshake, latch id/index/len, clear beat count and error flag, go to W_DATA. awready drops the next cycle.
  - W_DATA: wready=1. Each W handshake writes mem[index] when in range and the beat count <= len. Otherwise it drops the data and sets the error flag.
  - Error also sets when wlast arrives with beat count != len.
  - Beats with count > len and no wlast are dropped and flagged; the phase always ends on the wlast handshake, then go to W_RESP.
  - W_RESP: bvalid=1, bid=latched id, bresp = SLVERR (2'b10) if error else OKAY (2'b00). Hold stable until bready; on handshake go to W_IDLE. bvalid falls the next cycle.
  - Minimum AW-accept to AW-accept period for len=0: 4 cycles.
- Read FSM, R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: arready=1. On AR handshake, latch id/index/len and go to R_DATA. First rvalid appears the next cycle.
  - R_DATA: rvalid=1. rdata = mem[index] (asynchronous array read), or 0 with rresp=SLVERR when out of range; otherwise rresp=OKAY. rlast=1 when beat count == len.
  - Outputs are held stable while rready=0. On each handshake, increment index/count; on the rlast handshake go to R_IDLE.
- Write and read FSMs are independent and may run concurrently.
- Same-word write and read in the same cycle: R returns the pre-write value; the write is visible from the next cycle.
- W beats presented before AW are not accepted (wready=0 outside W_DATA).
- len=255: 256 beats; beat counter is TRANS_DATA_LEN_W+1 bits wide.
- Reset mid-burst: both FSMs return to IDLE immediately, all valids drop, and partial writes already committed remain in memory.

Decomposition:
- Package axi_mem_pkg: RESP_OKAY=2'b00, RESP_SLVERR=2'b10, write-FSM enum {W_IDLE,W_DATA,W_RESP}, read-FSM enum {R_IDLE,R_DATA}.
- Sub-module axi_mem_array: MEM_DEPTH x DATA_W storage, one synchronous write port (we, waddr, wdata) and one asynchronous read port (raddr -> rdata).
- Both FSMs live in axi_mem_slv.

Test Plan:
- Reset release -> awready=arready=1 on cycle 1. Write AW id=3, addr=0x40, len=3, data 0xA0..0xA3, wlast on beat 4 -> words 2..5 written; bvalid 1 cycle after wlast with bid=3, bresp=00.
- Read AR id=7, addr=0x40, len=3, rready toggled 1/0 -> 4 beats 0xA0..0xA3 stable while stalled, rresp=00, rlast only on beat 4, rid=7.
- AW addr=(MEM_DEPTH-2)*32, len=3 -> first 2 beats written, last 2 dropped, bresp=10. Matching AR -> beats 3,4 return rdata=0, rresp=10.
- AW len=1 with wlast on beat 1 (early) -> bresp=10. AW len=1 with 3 beats, wlast on beat 3 -> beat 3 dropped, bresp=10.
- Concurrent write and read of word 10 in the same cycle (old 0x11, new 0x22) -> R beat returns 0x11; a subsequent read returns 0x22. Also bready held 0 for 5 cycles -> bvalid/bid/bresp stable.
- aresetn asserted mid-write (beat 2 of 4) and mid-read -> all valids/readies 0 immediately. After release, new AW/AR are accepted normally and committed beats 1-2 read back intact.
